// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encodings,
// the default no-op word and the wait-state counter width.
package imem_responder_pkg;

   // Wait-state counter width; supports LATENCY up to 15.
   localparam int unsigned CNT_W = 4;

   // addi x0, x0, 0 -- returned for out-of-range reads and after reset.
   localparam logic [31:0] NOP_WORD = 32'h00000013;

   typedef enum logic [1:0] {
      IM_IDLE = 2'd0,
      IM_WAIT = 2'd1,
      IM_RESP = 2'd2
   } im_state_e;

endpackage

// File: rtl/imem_array.sv
// Program store: synchronous write, registered read. Reads of an address
// outside DEPTH return FILL with the error flag set. With IMEM_PARITY_EN
// defined, each word carries an even-parity bit that is checked on read and
// an inject_perr input corrupts the stored parity on write.
module imem_array
   import imem_responder_pkg::*;
#(
   parameter int unsigned       WIDTH = 32,
   parameter int unsigned       AW    = 5,
   parameter int unsigned       DEPTH = 32,
   parameter logic [WIDTH-1:0]  FILL  = WIDTH'(NOP_WORD)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd_en,
   input  logic [AW-1:0]    raddr,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
`ifdef IMEM_PARITY_EN
   input  logic             inject_perr,
`endif
   output logic [WIDTH-1:0] rdata,
   output logic             rerr
);

   localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic             w_ok;
   logic             r_ok;
   logic [IDXW-1:0]  widx;
   logic [IDXW-1:0]  ridx;

   assign w_ok = 32'(waddr) < DEPTH;
   assign r_ok = 32'(raddr) < DEPTH;
   assign widx = waddr[IDXW-1:0];
   assign ridx = raddr[IDXW-1:0];

   // Loader write; storage is deliberately not reset so a program survives reset.
   always_ff @(posedge clk) begin
      if (we && w_ok) begin
         mem[widx] <= wdata;
      end
   end

`ifdef IMEM_PARITY_EN
   logic par [DEPTH];

   // Parity column written alongside the data; inject flips it for testing.
   always_ff @(posedge clk) begin
      if (we && w_ok) begin
         par[widx] <= (^wdata) ^ inject_perr;
      end
   end

   // Registered read: old data is returned if a write hits the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= FILL;
         rerr  <= 1'b0;
      end else if (rd_en) begin
         if (r_ok) begin
            rdata <= mem[ridx];
            rerr  <= (^mem[ridx]) != par[ridx];
         end else begin
            rdata <= FILL;
            rerr  <= 1'b1;
         end
      end
   end
`else
   // Registered read: old data is returned if a write hits the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= FILL;
         rerr  <= 1'b0;
      end else if (rd_en) begin
         if (r_ok) begin
            rdata <= mem[ridx];
            rerr  <= 1'b0;
         end else begin
            rdata <= FILL;
            rerr  <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: memory side of the fetch syn/ack handshake.
// Captures a read request, waits LATENCY cycles, then pulses ack for one
// cycle with the registered word. Loader writes are independent of the FSM.
// Optional feature macro: IMEM_PARITY_EN (adds im_i_inject_perr and a parity
// check that raises im_o_err on mismatch).
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int unsigned        IWIDTH    = 32,
   parameter int unsigned        AWIDTH    = 5,
   parameter int unsigned        DEPTH     = 32,
   parameter int unsigned        LATENCY   = 1,
   parameter logic [IWIDTH-1:0]  NOP_INSTR = IWIDTH'(NOP_WORD)
) (
   input  logic              im_clk,
   input  logic              im_rst,
   input  logic              im_i_syn,
   input  logic [AWIDTH-1:0] im_i_addr,
   input  logic              im_i_flush,
   output logic              im_o_ack,
   output logic [IWIDTH-1:0] im_o_instr,
   output logic              im_o_err,
   input  logic              im_i_we,
   input  logic [AWIDTH-1:0] im_i_waddr,
   input  logic [IWIDTH-1:0] im_i_wdata,
`ifdef IMEM_PARITY_EN
   input  logic              im_i_inject_perr,
`endif
   output logic              im_o_busy
);

   // Counter preload: the WAIT state is left on the edge where it reads 0.
   localparam logic [CNT_W-1:0] LAT_LOAD =
      (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

   im_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic              rd_en;
   logic [AWIDTH-1:0] raddr;

   // State, counter and captured-address registers.
   always_ff @(posedge im_clk or negedge im_rst) begin
      if (!im_rst) begin
         state_q <= IM_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
      end
   end

   // Next-state logic; rd_en fires exactly on the edge that enters RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rd_en   = 1'b0;
      raddr   = addr_q;
      unique case (state_q)
         IM_IDLE: begin
            if (im_i_syn && !im_i_flush) begin
               addr_d = im_i_addr;
               if (LATENCY == 0) begin
                  // Zero wait states: the read uses the live address.
                  state_d = IM_RESP;
                  rd_en   = 1'b1;
                  raddr   = im_i_addr;
               end else begin
                  cnt_d   = LAT_LOAD;
                  state_d = IM_WAIT;
               end
            end
         end
         IM_WAIT: begin
            if (im_i_flush) begin
               state_d = IM_IDLE;
            end else if (cnt_q == '0) begin
               state_d = IM_RESP;
               rd_en   = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         IM_RESP: begin
            // Ack is committed; a flush here has no effect.
            state_d = IM_IDLE;
         end
         default: begin
            state_d = IM_IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      im_o_ack  = (state_q == IM_RESP);
      im_o_busy = (state_q != IM_IDLE);
   end

   imem_array #(
      .WIDTH (IWIDTH),
      .AW    (AWIDTH),
      .DEPTH (DEPTH),
      .FILL  (NOP_INSTR)
   ) u_array (
      .clk         (im_clk),
      .rst_n       (im_rst),
      .rd_en       (rd_en),
      .raddr       (raddr),
      .we          (im_i_we),
      .waddr       (im_i_waddr),
      .wdata       (im_i_wdata),
`ifdef IMEM_PARITY_EN
      .inject_perr (im_i_inject_perr),
`endif
      .rdata       (im_o_instr),
      .rerr        (im_o_err)
   );

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder: the memory end of the fetch syn/ack handshake. It accepts word-address read requests from the fetch stage, inserts a configurable number of wait states, and returns the instruction with a one-cycle ack pulse. A separate loader write port fills the program before or between runs. It sits between the fetch stage and the program store, alongside the processing unit.

Parameters:
IWIDTH, 32, instruction word width
AWIDTH, 5, word address width
DEPTH, 32, number of implemented words (must be <= 2^AWIDTH)
LATENCY, 1, wait-state cycles between request capture and ack (0..15)
NOP_INSTR, 32'h00000013, word returned on an out-of-range read

Ports:
im_clk  in  1  clock, rising edge
im_rst  in  1  asynchronous, active-low reset
im_i_syn  in  1  read request from fetch; held high until ack
im_i_addr  in  AWIDTH  word address; stable while im_i_syn is high
im_i_flush  in  1  abort any in-flight request
im_o_ack  out  1  one-cycle pulse; im_o_instr is valid in this cycle
im_o_instr  out  IWIDTH  returned instruction
im_o_err  out  1  valid with im_o_ack; address out of range, or parity fail when the optional feature is enabled
im_o_busy  out  1  high in WAIT and RESP
im_i_we  in  1  loader write enable
im_i_waddr  in  AWIDTH  loader word address
im_i_wdata  in  IWIDTH  loader data

Behaviour:
- Reset (im_rst low, async): state IDLE, counter 0. im_o_ack, im_o_err and im_o_busy are 0. im_o_instr is NOP_INSTR. Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: when im_i_syn is 1 and im_i_flush is 0 at an edge, capture the address.
  - LATENCY = 0: go to RESP.
  - Otherwise: load the counter with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. Leave for RESP on the edge where the counter is 0.
- Data sampling: the read of mem[captured address] is registered on the edge that enters RESP.
  - A loader write to the same address on that same edge is not seen; the old data is returned.
  - A write on any earlier edge is seen.
- RESP: im_o_ack = 1 for exactly this one cycle, then go to IDLE.
  - im_o_instr and im_o_err hold their values after ack until the next RESP.
- Latency: syn sampled at edge k gives ack high in the cycle after edge k+LATENCY.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
  - If syn is still high in the IDLE cycle after ack, that is a new request.
- Out of range (captured address >= DEPTH): im_o_instr = NOP_INSTR, im_o_err = 1. Loader writes with waddr >= DEPTH are ignored.
- Flush:
  - In WAIT: go to IDLE next edge with no ack.
  - In RESP: the ack still occurs that cycle (already committed).
  - In IDLE: blocks request capture.
- Loader writes are accepted in every state; they are independent of the FSM.
- im_o_busy = (state != IDLE).
- im_i_syn dropping during WAIT is a protocol violation. The FSM completes the request anyway.
- Reset mid-operation: immediate return to IDLE, ack suppressed.

Optional Feature:
IMEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit, computed on loader write.
  - On read, a parity mismatch sets im_o_err = 1 and returns the stored word unchanged.
  - Adds an input im_i_inject_perr (1 bit); when high during a write, the stored parity is inverted.
- Undefined: no parity storage and no port. im_o_err reflects out-of-range only.

Decomposition:
- Shared package/header: FSM state encodings (IM_IDLE, IM_WAIT, IM_RESP), the NOP_INSTR constant, and the latency counter width (4).
- One natural sub-module: imem_array, a synchronous-write, registered-read RAM with an optional parity column. The FSM and handshake stay in imem_responder.

Test Plan:
- Reset: im_rst low mid-WAIT -> ack 0, busy 0, instr = 32'h00000013 immediately. After release, a syn to addr 3 completes normally.
- LATENCY=1: load mem[2] = 32'h00500093; syn with addr 2 sampled at edge 0 -> ack high in the cycle after edge 1, instr = 32'h00500093, err 0. The next IDLE cycle with syn still high starts a new read.
- LATENCY=0: back-to-back reads of addr 0 and addr 1 -> each ack 1 cycle after capture, spacing 2 cycles, data correct.
- Out of range: DEPTH=32, AWIDTH=6, read addr 40 -> instr = 32'h00000013, err 1. A write to addr 40 is ignored.
- Flush in WAIT (LATENCY=4): flush in the 2nd wait cycle -> no ack, IDLE next cycle. A write to mem[5] on the RESP-entry edge -> a read of addr 5 returns the old word.
- With IMEM_PARITY_EN: write addr 7 with im_i_inject_perr = 1, then read -> err 1, data equals the written word. Addr 8 written without injection reads back with err 0.
